edge_detect_multi: RTL and testbench
====================================

# edge_detect_multi

Parametrised, multi-channel successor to the single-bit positive-edge Mealy detector. Each of WIDTH channels synchronises an asynchronous input, tracks its level with a small per-channel FSM, and emits a registered one-cycle pulse on a rising, falling or either edge, selected per channel at run time. Each channel also keeps a sticky event flag and a saturating edge counter that software can clear. The block sits between raw board or peripheral inputs and the control logic that consumes event strobes.

## Interface
- WIDTH, 4: number of independent channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (0 = input already synchronous, no flops).
- CNT_W, 8: width of each per-channel edge counter.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-low. Clears all state immediately; released synchronously by the system.
- din  in  WIDTH  raw channel inputs.
- mode  in  2*WIDTH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- clr  in  WIDTH  per-channel synchronous clear of sticky[i] and cnt[i].
- level  out  WIDTH  synchronised input (last synchroniser stage, or din when SYNC_STAGES=0).
- pulse  out  WIDTH  registered one-cycle edge strobe.
- any  out  1  registered OR of all pulse bits; asserted in the same cycles as pulse.
- sticky  out  WIDTH  set on a detected edge; held until cleared.
- cnt  out  WIDTH*CNT_W  channel i counter at [CNT_W*i +: CNT_W].

## Operation
- Synchroniser: chain of SYNC_STAGES flops per channel, reset to 0. s[i] is the chain output.
- Warm-up counter, shared by all channels: resets to 0, increments each cycle, saturates at SYNC_STAGES. ready = (count == SYNC_STAGES). With SYNC_STAGES=0, ready is true on the first edge.
- Per-channel FSM states are S_INIT, S_LO and S_HI. The reset state is S_INIT.
  - S_INIT: while !ready, hold. When ready, go to S_HI if s=1, else S_LO. No edge is reported on this transition.
  - S_LO: if s=1, go to S_HI; this is a rising edge. Otherwise hold.
  - S_HI: if s=0, go to S_LO; this is a falling edge. Otherwise hold.
- Edge qualify: det[i] = (rise & mode[2i]) | (fall & mode[2i+1]).
  - The FSM tracks level in every mode, including 00. Enabling a channel therefore never produces a spurious edge.
- Registered outputs, updated at the edge where the transition occurs:
  - pulse[i] <= det[i].
  - any <= |det.
- sticky[i]:
  - det wins over clr: if det[i], set.
  - else if clr[i], clear.
  - else hold.
- cnt[i]:
  - If clr[i] and det[i] together: load 1.
  - Else if clr[i]: load 0.
  - Else if det[i] and the count is below 2^CNT_W−1: increment.
  - At all-ones the counter saturates; it does not wrap.
- mode and clr are sampled at the same edge as the FSM transition and take effect there.

## Timing
- Reset values, applied asynchronously: level=0, pulse=0, any=0, sticky=0, all cnt=0, FSM=S_INIT, warm-up count=0.
- Latency: let N be the first clock edge that samples a new din level, with the channel out of S_INIT. pulse is high for exactly one cycle, from edge N+SYNC_STAGES to edge N+SYNC_STAGES+1.
  - sticky and cnt update at the same edge N+SYNC_STAGES.
- A din level must be held for at least one full clock period to be detected. Shorter glitches may be missed; this is acceptable.
- Input toggling every cycle in mode 11 gives pulse high continuously, one edge counted per cycle.
- An input high through reset release gives level=1 after SYNC_STAGES edges. The FSM enters S_HI with no pulse.
- Reset asserted mid-pulse forces all outputs to 0 without waiting for a clock edge. After release, the warm-up sequence repeats.
- Channels are fully independent. Simultaneous edges on several channels all pulse, and any=1 for one cycle.

## Test plan
Configuration for all scenarios: WIDTH=4, SYNC_STAGES=2, CNT_W=4.
- Reset release with din=4'hF and mode=8'hFF → no pulse ever; level=4'hF from the 2nd edge after release; sticky=0; all cnt=0.
- ch0 mode=01, din[0] 0→1 first sampled at edge N → pulse[0]=1 only between edges N+2 and N+3; any matches; sticky[0]=1; cnt0=1. A later 1→0 on din[0] → no pulse.
- ch1 mode=11, din[1] toggles every cycle for 20 cycles → pulse[1] high for 20 consecutive cycles; cnt1 stops at 4'hF; sticky[1]=1.
- ch2 mode=10, clr[2]=1 in the same cycle as a detected falling edge → sticky[2] stays 1 and cnt2=1. Then clr[2] alone → sticky[2]=0, cnt2=0.
- ch3 mode=00 while din[3] toggles, then mode=01 while din[3] is held high → no pulse, sticky[3]=0, cnt3=0. The next 0→1 → one pulse.
- Assert rst (low) while pulse[0]=1 → pulse, any, sticky and cnt are 0 before the next clk edge. After release, no pulse until warm-up completes and a real edge occurs.

Source files
------------

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronised edge detector with per-channel
// edge select, one-cycle strobes, sticky flags and saturating counters.
module edge_detect_multi #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic [2*WIDTH-1:0]     mode,
  input  logic [WIDTH-1:0]       clr,
  output logic [WIDTH-1:0]       level,
  output logic [WIDTH-1:0]       pulse,
  output logic                   any,
  output logic [WIDTH-1:0]       sticky,
  output logic [WIDTH*CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    S_INIT,
    S_LO,
    S_HI
  } state_t;

  localparam int WU_W =
    (SYNC_STAGES < 1) ? 1 : $clog2(SYNC_STAGES + 1);
  localparam logic [WU_W-1:0] WU_MAX = WU_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (SYNC_STAGES > 0) begin : g_sync
    logic [WIDTH-1:0] chain [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
          chain[k] <= '0;
        end
      end else begin
        chain[0] <= din;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          chain[k] <= chain[k-1];
        end
      end
    end

    assign level = chain[SYNC_STAGES-1];
  end else begin : g_nosync
    assign level = din;
  end

  // Channels stay in S_INIT until the synchroniser holds real data.
  logic [WU_W-1:0] wu;
  logic            ready;

  assign ready = (wu == WU_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wu <= '0;
    end else if (!ready) begin
      wu <= wu + WU_W'(1);
    end
  end

  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= S_INIT;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  always_comb begin
    rise = '0;
    fall = '0;
    det  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        S_INIT: begin
          if (ready) begin
            state_d[i] = level[i] ? S_HI : S_LO;
          end
        end
        S_LO: begin
          if (level[i]) begin
            state_d[i] = S_HI;
            rise[i]    = 1'b1;
          end
        end
        S_HI: begin
          if (!level[i]) begin
            state_d[i] = S_LO;
            fall[i]    = 1'b1;
          end
        end
        default: state_d[i] = S_INIT;
      endcase
      det[i] = (rise[i] & mode[2*i])
             | (fall[i] & mode[2*i+1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse  <= '0;
      any    <= 1'b0;
      sticky <= '0;
      cnt    <= '0;
    end else begin
      pulse <= det;
      any   <= |det;
      for (int i = 0; i < WIDTH; i++) begin
        if (det[i]) begin
          sticky[i] <= 1'b1;
        end else if (clr[i]) begin
          sticky[i] <= 1'b0;
        end
        if (clr[i]) begin
          cnt[CNT_W*i +: CNT_W] <=
            det[i] ? CNT_W'(1) : '0;
        end else if (det[i] &&
                     cnt[CNT_W*i +: CNT_W] != CNT_MAX) begin
          cnt[CNT_W*i +: CNT_W] <=
            cnt[CNT_W*i +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi (WIDTH=4, SYNC_STAGES=2, CNT_W=4);
// expectations are queued with a due cycle and checked as cycles elapse.
module tb_edge_detect_multi;

  localparam int PUL = 0;
  localparam int ANY = 1;
  localparam int STK = 2;
  localparam int CNT = 3;
  localparam int LVL = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  din;
  logic [7:0]  mode;
  logic [3:0]  clr;
  logic [3:0]  level;
  logic [3:0]  pulse;
  logic        any;
  logic [3:0]  sticky;
  logic [15:0] cnt;

  edge_detect_multi #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .mode(mode),
    .clr(clr),
    .level(level),
    .pulse(pulse),
    .any(any),
    .sticky(sticky),
    .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       tag;
    int          fld;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [15:0] obs(int fld);
    case (fld)
      PUL:     return {12'h0, pulse};
      ANY:     return {15'h0, any};
      STK:     return {12'h0, sticky};
      CNT:     return cnt;
      default: return {12'h0, level};
    endcase
  endfunction

  task automatic cmp(string tag, logic [15:0] o,
                     logic [15:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic push(int d, string tag, int fld,
                      logic [15:0] v);
    exp_t e;
    e.due = cyc + d;
    e.tag = tag;
    e.fld = fld;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_rng(int d0, int d1, string tag,
                          int fld, logic [15:0] v);
    for (int d = d0; d <= d1; d++) begin
      push(d, tag, fld, v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        cmp(sb[i].tag, obs(sb[i].fld), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    din  = 4'hF;
    mode = 8'hFF;
    clr  = 4'h0;
    #2 rst = 1'b0;
    #1;
    cmp("rst_level", obs(LVL), 16'h0);
    cmp("rst_pulse", obs(PUL), 16'h0);
    cmp("rst_any", obs(ANY), 16'h0);
    cmp("rst_sticky", obs(STK), 16'h0);
    cmp("rst_cnt", obs(CNT), 16'h0);
    tick();
    tick();
    cmp("rst_hold_level", obs(LVL), 16'h0);

    // release with all inputs high and all edges enabled
    #2 rst = 1'b1;
    push(1, "wu_level_e1", LVL, 16'h0);
    push(2, "wu_level_e2", LVL, 16'hF);
    push_rng(1, 10, "wu_pulse", PUL, 16'h0);
    push_rng(1, 10, "wu_any", ANY, 16'h0);
    push(10, "wu_sticky", STK, 16'h0);
    push(10, "wu_cnt", CNT, 16'h0);
    repeat (10) tick();

    // all channels fall while disabled
    mode = 8'h00;
    din  = 4'h0;
    push_rng(1, 6, "off_pulse", PUL, 16'h0);
    push(6, "off_sticky", STK, 16'h0);
    repeat (6) tick();

    // ch0 rising only
    mode   = 8'h01;
    din[0] = 1'b1;
    push(2, "c0_pre", PUL, 16'h0);
    push(3, "c0_pulse", PUL, 16'h1);
    push(3, "c0_any", ANY, 16'h1);
    push(3, "c0_sticky", STK, 16'h1);
    push(3, "c0_cnt", CNT, 16'h0001);
    push(4, "c0_end", PUL, 16'h0);
    push(4, "c0_any_end", ANY, 16'h0);
    repeat (6) tick();
    din[0] = 1'b0;
    push_rng(1, 5, "c0_fall", PUL, 16'h0);
    push(5, "c0_cnt_hold", CNT, 16'h0001);
    repeat (5) tick();

    // ch1 both edges, toggling every cycle
    mode = 8'h0C;
    push(2, "c1_pre", PUL, 16'h0);
    push_rng(3, 22, "c1_run", PUL, 16'h2);
    push(12, "c1_any", ANY, 16'h1);
    push(23, "c1_end", PUL, 16'h0);
    push(23, "c1_cnt_sat", CNT, 16'h00F1);
    push(23, "c1_sticky", STK, 16'h3);
    for (int k = 0; k < 20; k++) begin
      din[1] = ~din[1];
      tick();
    end
    repeat (4) tick();

    // ch2 falling only; clear coincident with an edge
    mode   = 8'h20;
    din[2] = 1'b1;
    push_rng(1, 5, "c2_rise_off", PUL, 16'h0);
    repeat (5) tick();
    din[2] = 1'b0;
    push(3, "c2_pulse", PUL, 16'h4);
    push(3, "c2_sticky", STK, 16'h7);
    push(3, "c2_cnt", CNT, 16'h01F1);
    tick();
    tick();
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    tick();
    tick();
    clr[2] = 1'b1;
    push(1, "c2_clr_stk", STK, 16'h3);
    push(1, "c2_clr_cnt", CNT, 16'h00F1);
    tick();
    clr[2] = 1'b0;
    tick();

    // ch3 toggles while off, then enabled while high
    mode = 8'h00;
    push_rng(1, 8, "c3_off", PUL, 16'h0);
    for (int k = 0; k < 5; k++) begin
      din[3] = ~din[3];
      tick();
    end
    repeat (3) tick();
    mode = 8'h40;
    push_rng(1, 5, "c3_en", PUL, 16'h0);
    push(5, "c3_stk", STK, 16'h3);
    push(5, "c3_cnt", CNT, 16'h00F1);
    repeat (5) tick();
    din[3] = 1'b0;
    push_rng(1, 4, "c3_fall", PUL, 16'h0);
    repeat (4) tick();
    din[3] = 1'b1;
    push(2, "c3_pre", PUL, 16'h0);
    push(3, "c3_pulse", PUL, 16'h8);
    push(3, "c3_any", ANY, 16'h1);
    push(3, "c3_cnt1", CNT, 16'h10F1);
    push(3, "c3_stk1", STK, 16'hB);
    push(4, "c3_end", PUL, 16'h0);
    repeat (5) tick();

    // reset asserted while ch0 pulses
    mode   = 8'h01;
    din[0] = 1'b1;
    push(3, "g_pulse", PUL, 16'h1);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    cmp("g_rst_pulse", obs(PUL), 16'h0);
    cmp("g_rst_any", obs(ANY), 16'h0);
    cmp("g_rst_sticky", obs(STK), 16'h0);
    cmp("g_rst_cnt", obs(CNT), 16'h0);
    cmp("g_rst_level", obs(LVL), 16'h0);
    tick();
    #2 rst = 1'b1;
    push(2, "g_level", LVL, 16'h9);
    push_rng(1, 8, "g_warm", PUL, 16'h0);
    push(8, "g_cnt", CNT, 16'h0);
    repeat (8) tick();
    din[0] = 1'b0;
    push_rng(1, 4, "g_fall", PUL, 16'h0);
    repeat (4) tick();
    din[0] = 1'b1;
    push(3, "g_edge", PUL, 16'h1);
    push(3, "g_cnt_e", CNT, 16'h0001);
    push(4, "g_end", PUL, 16'h0);
    repeat (5) tick();

    cmp("sb_drained", 16'(sb.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
